// File: rtl/traceback_unit.sv
// Viterbi traceback unit for a K=3 (4-state) trellis.
// Buffers TB_DEPTH survivor decision vectors in a circular memory. Once the
// window is full, it traces back from the minimum-cost state of the newest
// step and emits the decoded bit of the oldest buffered step.
module traceback_unit #(
    parameter int TB_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] dec,
    input  logic [1:0] min_state,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_bit
);

    localparam int PW = $clog2(TB_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(TB_DEPTH);
    localparam logic [CW-1:0] DEPTH_M1_C = CW'(TB_DEPTH - 1);
    localparam logic [PW-1:0] STEP_INI_C = PW'(TB_DEPTH - 1);
    localparam logic [PW-1:0] STEP_ONE_C = PW'(1);
    localparam logic [PW-1:0] PTR_ONE_C  = PW'(1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        TRACE = 2'd1,
        EMIT  = 2'd2
    } state_t;

    // Predecessor of state s: the older bit shifts up, the decision supplies
    // the bit that fell off the end of the shift register.
    function automatic logic [1:0] pred_state(input logic [1:0] s, input logic [3:0] d);
        return {s[0], d[s]};
    endfunction

    state_t          state_r,     state_s;
    logic [PW-1:0]   wr_ptr_r,    wr_ptr_s;
    logic [PW-1:0]   rd_ptr_r,    rd_ptr_s;
    logic [CW-1:0]   count_r,     count_s;
    logic [PW-1:0]   step_cnt_r,  step_cnt_s;
    logic [1:0]      cur_state_r, cur_state_s;
    logic            out_valid_r, out_valid_s;
    logic            out_bit_r,   out_bit_s;
    logic            in_ready_r,  in_ready_s;
    logic            accept_s;
    logic [3:0]      mem_r [TB_DEPTH];

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_bit   = out_bit_r;

    // An entry is only taken while filling; in_ready_r mirrors state FILL.
    assign accept_s = in_ready_r & in_valid;

    // Survivor memory write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= dec;
        end
    end

    // Next-state logic of the FILL / TRACE / EMIT sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            FILL: begin
                if (accept_s && (count_r >= DEPTH_M1_C)) begin
                    state_s = TRACE;
                end else begin
                    state_s = FILL;
                end
            end
            TRACE: begin
                if (step_cnt_r == STEP_ONE_C) begin
                    state_s = EMIT;
                end else begin
                    state_s = TRACE;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    state_s = FILL;
                end else begin
                    state_s = EMIT;
                end
            end
            default: begin
                state_s = FILL;
            end
        endcase
    end

    // Datapath next values: write pointer, fill count and traceback walk.
    always_comb begin
        wr_ptr_s    = wr_ptr_r;
        rd_ptr_s    = rd_ptr_r;
        count_s     = count_r;
        step_cnt_s  = step_cnt_r;
        cur_state_s = cur_state_r;
        case (state_r)
            FILL: begin
                if (accept_s) begin
                    wr_ptr_s = wr_ptr_r + PTR_ONE_C;
                    if (count_r != DEPTH_C) begin
                        count_s = count_r + CW'(1);
                    end else begin
                        count_s = count_r;
                    end
                    if (count_r >= DEPTH_M1_C) begin
                        cur_state_s = min_state;
                        rd_ptr_s    = wr_ptr_r;
                        step_cnt_s  = STEP_INI_C;
                    end else begin
                        cur_state_s = cur_state_r;
                    end
                end else begin
                    wr_ptr_s = wr_ptr_r;
                end
            end
            TRACE: begin
                cur_state_s = pred_state(cur_state_r, mem_r[rd_ptr_r]);
                rd_ptr_s    = rd_ptr_r - PTR_ONE_C;
                step_cnt_s  = step_cnt_r - STEP_ONE_C;
            end
            EMIT: begin
                cur_state_s = cur_state_r;
            end
            default: begin
                cur_state_s = cur_state_r;
            end
        endcase
    end

    // Output next values, derived from the next state so outputs can be registered.
    always_comb begin
        out_valid_s = 1'b0;
        out_bit_s   = 1'b0;
        in_ready_s  = 1'b0;
        case (state_s)
            FILL: begin
                in_ready_s = 1'b1;
            end
            TRACE: begin
                in_ready_s = 1'b0;
            end
            EMIT: begin
                out_valid_s = 1'b1;
                out_bit_s   = cur_state_s[1];
            end
            default: begin
                in_ready_s = 1'b1;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= FILL;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            step_cnt_r  <= '0;
            cur_state_r <= 2'b00;
            out_valid_r <= 1'b0;
            out_bit_r   <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_s;
            wr_ptr_r    <= wr_ptr_s;
            rd_ptr_r    <= rd_ptr_s;
            count_r     <= count_s;
            step_cnt_r  <= step_cnt_s;
            cur_state_r <= cur_state_s;
            out_valid_r <= out_valid_s;
            out_bit_r   <= out_bit_s;
            in_ready_r  <= in_ready_s;
        end
    end

endmodule

// File: tb/tb_traceback_unit.sv
// Directed testbench for traceback_unit (TB_DEPTH = 8).
module tb_traceback_unit;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] dec       = 4'h0;
    logic [1:0] min_state = 2'b00;
    logic       in_ready;
    logic       out_valid;
    logic       out_bit;

    int checks = 0;
    int errors = 0;

    // 10 time-unit clock.
    always #5 clk = ~clk;

    traceback_unit #(.TB_DEPTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dec       (dec),
        .min_state (min_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_bit",   {31'd0, out_bit},   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [3:0] d, input logic [1:0] m);
        @(negedge clk);
        chk("push_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        dec       = d;
        min_state = m;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid after an accepting push; checks latency 7.
    task automatic wait_out();
        int  lat;
        logic seen;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) begin
                seen = 1'b1;
            end else begin
                chk("trace_in_ready", {31'd0, in_ready}, 32'd0);
            end
        end
        chk("latency", lat, 32'd7);
        chk("emit_in_ready", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("post_emit_valid", {31'd0, out_valid}, 32'd0);
        chk("post_emit_ready", {31'd0, in_ready},  32'd1);
    endtask

    initial begin
        logic msg [20];
        logic p1, p2, b;
        int   r1, r2, c;
        logic prev;

        msg = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                1'b1, 1'b0, 1'b1, 1'b1};

        // Reset, 7 accepts of zero: no output; 8th accept: output 0 after 7 clocks.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            push(4'h0, 2'b00);
            chk("fill_out_valid", {31'd0, out_valid}, 32'd0);
            chk("fill_in_ready",  {31'd0, in_ready},  32'd1);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("idle7_out_valid", {31'd0, out_valid}, 32'd0);
        end
        push(4'h0, 2'b00);
        wait_out();
        chk("zeros_out_bit", {31'd0, out_bit}, 32'd0);
        release_out();

        // All-ones trellis: out_bit 1, 9-clock spacing with out_ready held.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push(4'hF, 2'b11);
        end
        in_valid  = 1'b1;
        dec       = 4'hF;
        min_state = 2'b11;
        out_ready = 1'b1;
        r1 = 0;
        r2 = 0;
        prev = 1'b0;
        for (c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (out_valid && !prev) begin
                chk("ones_out_bit", {31'd0, out_bit}, 32'd1);
                if (r1 == 0) begin
                    r1 = c;
                end else if (r2 == 0) begin
                    r2 = c;
                end
            end
            prev = out_valid;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("ones_first_rise", r1, 32'd7);
        chk("ones_spacing", r2 - r1, 32'd9);

        // Message stream with ideal decisions, crossing pointer wrap twice.
        do_reset();
        p1 = 1'b0;
        p2 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            b = msg[i];
            push({4{p2}}, {b, p1});
            p2 = p1;
            p1 = b;
            if (i >= 7) begin
                wait_out();
                chk($sformatf("msg_bit_%0d", i - 7), {31'd0, out_bit}, {31'd0, msg[i - 7]});
                release_out();
            end
        end

        // Back-pressure in EMIT: outputs hold and in_valid pulses are not written.
        do_reset();
        p1 = 1'b0;
        p2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b = msg[i];
            push({4{p2}}, {b, p1});
            p2 = p1;
            p1 = b;
        end
        wait_out();
        @(negedge clk);
        in_valid  = 1'b1;
        dec       = 4'hF;
        min_state = 2'b11;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_out_bit",   {31'd0, out_bit},   32'd1);
            chk("hold_in_ready",  {31'd0, in_ready},  32'd0);
        end
        in_valid = 1'b0;
        release_out();
        // Next message step is bit 1 after bits (.., 1, 0): window now starts at msg[1].
        push(4'hF, 2'b10);
        wait_out();
        chk("after_hold_bit", {31'd0, out_bit}, 32'd0);
        release_out();

        // Reset during TRACE step 3 aborts immediately; 8 fresh entries needed.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push(4'hF, 2'b11);
        end
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready",  {31'd0, in_ready},  32'd1);
        chk("abort_out_bit",   {31'd0, out_bit},   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
        end
        for (int i = 0; i < 7; i++) begin
            push(4'hF, 2'b11);
        end
        repeat (9) begin
            @(posedge clk);
            #1;
            chk("refill_no_valid", {31'd0, out_valid}, 32'd0);
            chk("refill_in_ready", {31'd0, in_ready},  32'd1);
        end
        push(4'hF, 2'b11);
        wait_out();
        chk("refill_out_bit", {31'd0, out_bit}, 32'd1);
        release_out();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
